// File: rtl/var_mem_pkg.sv
// Purpose: shared state encoding, default free-bitmap address and reset pattern for var_mem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package var_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int FREE_ADDR_DEFAULT = 1;

  // Reset fill bit for word idx: the free bitmap starts all ones, other words all zeros.
  function automatic logic reset_fill(input int idx, input int free_addr);
    return (idx == free_addr);
  endfunction

endpackage

// File: rtl/var_mem_array.sv
// Purpose: per-variable bitmap register file, free bitmap word preset to all ones on reset.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; always accepts a write when wr_en is high.
module var_mem_array
  import var_mem_pkg::*;
#(
  parameter int VAR_NUM    = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int FREE_ADDR  = FREE_ADDR_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [VAR_NUM-1:0]    wr_dat,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [VAR_NUM-1:0]    rd_dat
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [VAR_NUM-1:0] mem [DEPTH];

  // Storage: reset pattern on async reset, otherwise single synchronous write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {VAR_NUM{reset_fill(i, FREE_ADDR)}};
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Combinational read port.
  always_comb begin
    rd_dat = mem[rd_addr];
  end

endmodule

// File: rtl/var_mem_responder.sv
// Purpose: serves one read/write of the variable-state bitmaps per active-low request.
// Latency: request sampled low at edge N -> mem_work strobe after edge N+1 (cycle N+2).
// Backpressure: requester must release mem_request (drive 1) before the next access is taken.
module var_mem_responder
  import var_mem_pkg::*;
#(
  parameter int VAR_NUM    = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int FREE_ADDR  = FREE_ADDR_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_request,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [VAR_NUM-1:0]    d_in,
  output logic [VAR_NUM-1:0]    d_out,
  output logic                  mem_work,
  output logic                  mem_err
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [VAR_NUM-1:0]    din_q;
  logic                  rd_q, wr_q;
  logic                  capture_en;
  logic                  access_en;
  logic                  req_ok;
  logic                  wr_en;
  logic [VAR_NUM-1:0]    rd_dat;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state enables; RELEASE always lasts at least one cycle.
  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    access_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mem_request) begin
          capture_en = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        access_en = 1'b1;
        state_d   = RESPOND;
      end
      RESPOND: state_d = RELEASE;
      RELEASE: if (mem_request) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request is well formed only when exactly one of read/write is set.
  always_comb begin
    req_ok = rd_q ^ wr_q;
    wr_en  = access_en && req_ok && wr_q;
  end

  // Request latches: inputs are only looked at on the IDLE->ACCESS edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      din_q  <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else if (capture_en) begin
      addr_q <= address;
      din_q  <= d_in;
      rd_q   <= data_read;
      wr_q   <= data_write;
    end
  end

  // Read data and completion strobes; strobes are high exactly while in RESPOND.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_out    <= '0;
      mem_work <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      mem_work <= access_en;
      mem_err  <= access_en && !req_ok;
      if (access_en && req_ok && rd_q) d_out <= rd_dat;
    end
  end

  var_mem_array #(
    .VAR_NUM    (VAR_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FREE_ADDR  (FREE_ADDR)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (addr_q),
    .wr_dat  (din_q),
    .rd_addr (addr_q),
    .rd_dat  (rd_dat)
  );

endmodule

// File: tb/tb_var_mem_responder.sv
// Purpose: directed self-checking bench for var_mem_responder.
// Latency: checks strobe timing relative to the request sampling edge.
// Backpressure: exercises held-low requests and early release.
module tb_var_mem_responder;

  logic       clock;
  logic       reset;
  logic       mem_request;
  logic       data_read;
  logic       data_write;
  logic [1:0] address;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       mem_work;
  logic       mem_err;

  int n_cmp;
  int n_err;
  int pulses;

  var_mem_responder #(
    .VAR_NUM    (8),
    .ADDR_WIDTH (2),
    .FREE_ADDR  (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_request (mem_request),
    .data_read   (data_read),
    .data_write  (data_write),
    .address     (address),
    .d_in        (d_in),
    .d_out       (d_out),
    .mem_work    (mem_work),
    .mem_err     (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full access with early release; checks strobe timing, error flag and d_out.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [1:0] a, input logic [7:0] d,
                           input logic exp_err, input logic [7:0] exp_dout);
    @(negedge clock);
    mem_request = 1'b0;
    data_read   = rd;
    data_write  = wr;
    address     = a;
    d_in        = d;
    @(posedge clock); #1;               // edge N: request sampled
    mem_request = 1'b1;
    check_eq({tag, "_work_access"}, {31'd0, mem_work}, 32'd0);
    @(posedge clock); #1;               // edge N+1: RESPOND
    check_eq({tag, "_work"}, {31'd0, mem_work}, 32'd1);
    check_eq({tag, "_err"},  {31'd0, mem_err},  {31'd0, exp_err});
    check_eq({tag, "_dout"}, {24'd0, d_out},    {24'd0, exp_dout});
    @(posedge clock); #1;               // edge N+2: RELEASE
    check_eq({tag, "_work_release"}, {31'd0, mem_work}, 32'd0);
    @(posedge clock); #1;               // edge N+3: back to IDLE
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    mem_request = 1'b1;
    data_read   = 1'b0;
    data_write  = 1'b0;
    address     = 2'd0;
    d_in        = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_dout", {24'd0, d_out}, 32'h00);
    check_eq("rst_work", {31'd0, mem_work}, 32'd0);
    check_eq("rst_err",  {31'd0, mem_err},  32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Free bitmap starts all ones; other words zero.
    do_access("rd_free",   1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'hFF);
    do_access("wr_free",   1'b0, 1'b1, 2'd1, 8'hFE, 1'b0, 8'hFF);
    do_access("rd_free2",  1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'hFE);
    do_access("rd_a2",     1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00);
    // Malformed requests: no array change, d_out held.
    do_access("bad_both",  1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 8'h00);
    do_access("rd_after",  1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'hFE);
    do_access("bad_none",  1'b0, 1'b0, 2'd2, 8'hFF, 1'b1, 8'hFE);
    do_access("rd_a2b",    1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00);
    do_access("rd_a3",     1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00);

    // Request held low for 10 cycles: exactly one strobe.
    @(negedge clock);
    mem_request = 1'b0;
    data_read   = 1'b1;
    data_write  = 1'b0;
    address     = 2'd1;
    pulses      = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (mem_work) pulses++;
    end
    check_eq("hold_pulses", pulses, 32'd1);
    check_eq("hold_dout", {24'd0, d_out}, 32'hFE);
    @(negedge clock);
    mem_request = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    mem_request = 1'b0;
    pulses      = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (mem_work) pulses++;
    end
    check_eq("rereq_pulses", pulses, 32'd1);
    @(negedge clock);
    mem_request = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Inputs changed during ACCESS must not redirect the write.
    @(negedge clock);
    mem_request = 1'b0;
    data_read   = 1'b0;
    data_write  = 1'b1;
    address     = 2'd2;
    d_in        = 8'hA5;
    @(posedge clock); #1;
    mem_request = 1'b1;
    address     = 2'd3;
    d_in        = 8'h3C;
    data_read   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    do_access("late_a2",   1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 8'hA5);
    do_access("late_a3",   1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00);

    // Reset during ACCESS of a write: no strobe, array back to reset pattern.
    @(negedge clock);
    mem_request = 1'b0;
    data_read   = 1'b0;
    data_write  = 1'b1;
    address     = 2'd1;
    d_in        = 8'h00;
    @(posedge clock); #1;
    reset       = 1'b0;
    mem_request = 1'b1;
    pulses      = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (mem_work) pulses++;
    end
    check_eq("rstacc_pulses", pulses, 32'd0);
    check_eq("rstacc_dout", {24'd0, d_out}, 32'h00);
    @(negedge clock);
    reset = 1'b1;
    do_access("rstacc_rd1", 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'hFF);
    do_access("rstacc_rd2", 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
